// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the dual-port RAM bank.
// Holds the FSM state type, read-during-write mode codes and the byte merge.
package dp_ram_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // One byte lane of a byte-enabled write: keep the old byte unless enabled.
    function automatic logic [7:0] be_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be
    );
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Read-response pipeline: RD_LAT-deep shift of valid/data, flushed on rst.
// Ports: clk, rst, in_valid/in_data (accepted read), rvalid/rdata (response).
module dp_ram_rd_pipe
    import dp_ram_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata
);

    logic [RD_LAT-1:0] v;
    logic [WIDTH-1:0]  d [RD_LAT];

    // Data is zeroed on entry when not valid, so every stage is 0 when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                d[i] <= '0;
            end
        end else begin
            v[0] <= in_valid;
            d[0] <= in_valid ? in_data : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
        end
    end

    assign rvalid = v[RD_LAT-1];
    assign rdata  = d[RD_LAT-1];

endmodule

// File: rtl/dp_ram_bank.sv
// True dual-port RAM with valid/ready request ports, byte enables and init sweep.
// Ports: clk, rst, port A/B request + read response, col_err collision pulse.
module dp_ram_bank
    import dp_ram_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int BE_WIDTH   = WIDTH / 8,
    parameter int RD_LAT     = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_wr_rd,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [BE_WIDTH-1:0]   a_be,
    input  logic [WIDTH-1:0]      a_wdata,
    output logic                  a_rvalid,
    output logic [WIDTH-1:0]      a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_wr_rd,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [BE_WIDTH-1:0]   b_be,
    input  logic [WIDTH-1:0]      b_wdata,
    output logic                  b_rvalid,
    output logic [WIDTH-1:0]      b_rdata,
    output logic                  col_err
);

    if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
        $error("dp_ram_bank: RD_LAT must be 1 or 2");
    end
    if (WIDTH % 8 != 0) begin : g_bad_width
        $error("dp_ram_bank: WIDTH must be a multiple of 8");
    end
    if (BE_WIDTH != WIDTH / 8) begin : g_bad_be
        $error("dp_ram_bank: BE_WIDTH must equal WIDTH/8");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]      mem [DEPTH];
    state_t                state;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  rdy;

    logic a_inr, b_inr;
    logic a_acc, b_acc;
    logic a_we, b_we;
    logic a_re, b_re;
    logic same;

    logic [WIDTH-1:0] a_old, b_old;
    logic [WIDTH-1:0] a_base;
    logic [WIDTH-1:0] a_word, b_word;
    logic [WIDTH-1:0] a_rd_word, b_rd_word;

    // A full power-of-two array has no out-of-range addresses.
    if (DEPTH == (1 << ADDR_WIDTH)) begin : g_pow2
        assign a_inr = 1'b1;
        assign b_inr = 1'b1;
    end else begin : g_npow2
        localparam logic [ADDR_WIDTH-1:0] LIM = ADDR_WIDTH'(DEPTH);
        assign a_inr = a_addr < LIM;
        assign b_inr = b_addr < LIM;
    end

    assign rdy     = (state == RUN);
    assign a_ready = rdy;
    assign b_ready = rdy;

    assign a_acc = a_valid & rdy;
    assign b_acc = b_valid & rdy;
    assign a_we  = a_acc & a_wr_rd & a_inr;
    assign b_we  = b_acc & b_wr_rd & b_inr;
    assign a_re  = a_acc & ~a_wr_rd;
    assign b_re  = b_acc & ~b_wr_rd;
    assign same  = (a_addr == b_addr);

    assign a_old = mem[a_addr];
    assign b_old = mem[b_addr];

    // B merges into the stored word; A merges on top of that when both hit
    // the same address, so A wins its enabled bytes and B keeps the rest.
    always_comb begin
        b_word = b_old;
        for (int i = 0; i < BE_WIDTH; i++) begin
            b_word[8*i +: 8] = be_merge(
                b_old[8*i +: 8], b_wdata[8*i +: 8], b_be[i]);
        end
        a_base = (b_we && same) ? b_word : a_old;
        a_word = a_base;
        for (int i = 0; i < BE_WIDTH; i++) begin
            a_word[8*i +: 8] = be_merge(
                a_base[8*i +: 8], a_wdata[8*i +: 8], a_be[i]);
        end
    end

    // Reader sees either the stored word or the other port's merged write.
    always_comb begin
        a_rd_word = '0;
        if (a_inr) begin
            a_rd_word = (RDW_MODE == RDW_NEW && b_we && same)
                        ? b_word : a_old;
        end
        b_rd_word = '0;
        if (b_inr) begin
            b_rd_word = (RDW_MODE == RDW_NEW && a_we && same)
                        ? a_word : b_old;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            init_addr <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    if (init_addr == LAST_ADDR) begin
                        state <= RUN;
                    end else begin
                        init_addr <= init_addr + 1'b1;
                    end
                end
                RUN:     state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    // A is written last so its bytes take precedence on a shared address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[init_addr] <= '0;
            end else begin
                if (b_we) mem[b_addr] <= b_word;
                if (a_we) mem[a_addr] <= a_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_err <= 1'b0;
        end else begin
            col_err <= a_acc & b_acc & a_wr_rd & b_wr_rd & same;
        end
    end

    dp_ram_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_a_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (a_re),
        .in_data  (a_rd_word),
        .rvalid   (a_rvalid),
        .rdata    (a_rdata)
    );

    dp_ram_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_b_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_re),
        .in_data  (b_rd_word),
        .rvalid   (b_rvalid),
        .rdata    (b_rdata)
    );

endmodule

// File: doc/dp_ram_bank.md
Name: dp_ram_bank

Overview:
- Parametrised true dual-port RAM; successor to the team's single-port valid/ready memory.
- Two independent request ports (A, B), each with a valid/ready handshake, byte write enables and a configurable read latency.
- After reset, a hardware init sweep clears the array one word per cycle.
- Used as a shared scratchpad between two masters, e.g. a DMA and a CPU-side engine.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; need not be a power of 2.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- BE_WIDTH, WIDTH/8, byte-enable width.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, cross-port read-during-write result: 0 = old data, 1 = new data.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- a_valid  in  1  port A request valid.
- a_ready  out  1  port A can accept a request.
- a_wr_rd  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  word address.
- a_be  in  BE_WIDTH  byte enables for writes; ignored on reads.
- a_wdata  in  WIDTH  write data.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  WIDTH  port A read data.
- b_valid, b_ready, b_wr_rd, b_addr, b_be, b_wdata, b_rvalid, b_rdata: same as port A, for port B.
- col_err  out  1  one-cycle pulse: same-address write/write collision.

Behaviour:
- Reset (synchronous, active-high):
  - Registered outputs are 0 while rst is high and on the first cycle after: a_ready, b_ready, a_rvalid, b_rvalid, a_rdata, b_rdata, col_err.
  - The read pipelines are flushed.
- FSM states:
  - INIT: entered from rst. Counter init_addr starts at 0 and writes 0 to mem[init_addr] each cycle. Readies stay low. Leaves for RUN after writing DEPTH-1, so the sweep takes exactly DEPTH cycles.
  - RUN: a_ready and b_ready are held at 1.
- Reset mid-operation: rst in any state aborts the cycle and discards in-flight reads (no rvalid is produced for them). The FSM restarts INIT from address 0.
- Accept rule: a request is accepted when valid && ready on a clock edge. There is no backpressure in RUN. Requests presented during INIT are not accepted, and the master must hold them.
- Write:
  - For each i with be[i] = 1, byte i of mem[addr] takes wdata byte i at the accepting edge.
  - be = 0 is a legal no-op.
  - Writes produce no response.
- Read:
  - rvalid pulses exactly RD_LAT cycles after the accepting edge.
  - rdata carries the word during the rvalid cycle and is 0 in every other cycle.
  - Back-to-back reads stream at one per cycle per port.
  - RD_LAT = 2 adds one output register stage and changes no other behaviour.
- Out-of-range (addr >= DEPTH): the request is accepted. A write is dropped. A read returns 0 with normal rvalid timing.
- Simultaneous events on the same edge:
  - A write and B write, same address: per byte, A wins where a_be = 1. Bytes written only by B take B's data. col_err pulses 1 cycle later.
  - Writes to different addresses: both proceed, no col_err.
  - One port writes and the other reads the same address:
    - RDW_MODE = 0: the reader gets the pre-write word.
    - RDW_MODE = 1: the reader gets the merged post-write word.
    - col_err is not asserted.
  - Both ports read the same address: both get the same data.
- Elaboration errors: RD_LAT outside {1, 2}, or WIDTH % 8 != 0.

Decomposition:
- Package dp_ram_pkg holds:
  - typedef state_t {INIT, RUN};
  - constants RDW_OLD = 0, RDW_NEW = 1;
  - a function be_merge(old, new, be) shared by both ports.
- One sub-module, dp_ram_rd_pipe, instantiated once per port. It is a RD_LAT-deep shift of valid/data with flush on rst, and it forces rdata to 0 when not valid.

Test Plan:
- Reset sweep: preload mem[5] = 0xDEADBEEF, pulse rst for 1 cycle → readies are 0 for 64 cycles then 1; a subsequent A read of 5 returns 0x00000000.
- Byte-enable write:
  - A writes addr 3 = 0x11223344 with be = 0xF.
  - Then A writes addr 3 = 0xAABBCCDD with be = 0x5.
  - → an A read of 3 returns 0x11BB33DD with rvalid exactly RD_LAT cycles after accept (check RD_LAT = 1 and 2).
- Write/write collision:
  - Same cycle: A writes addr 7 = 0x000000AA with be = 0x1, and B writes addr 7 = 0x0000BBCC with be = 0x3.
  - → mem[7] = 0x0000BBAA, and col_err is 1 for exactly one cycle.
- Cross-port read-during-write:
  - mem[9] = 0x1, then A writes 9 = 0x2 while B reads 9 in the same cycle.
  - → b_rdata = 0x1 with RDW_MODE = 0, and 0x2 with RDW_MODE = 1.
- Reset mid-stream: B issues reads on 4 consecutive cycles, rst asserts on the 2nd → no further b_rvalid, b_rdata = 0, init sweep restarts from 0.
- Out-of-range: DEPTH = 48, A writes addr 50 = 0xFF then reads 50 → rvalid with rdata 0; mem[50 mod 48 = 2] is unchanged.
